// File: rtl/univ_shift_reg.sv
// univ_shift_reg: bidirectional shift/rotate register with parallel load, shift counter and done pulse
module univ_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [2:0]                      mode,
  input  logic [WIDTH-1:0]                sin_r,
  input  logic [WIDTH-1:0]                sin_l,
  input  logic [WIDTH*DEPTH-1:0]          pin,
  output logic [WIDTH*DEPTH-1:0]          q,
  output logic [WIDTH-1:0]                sout_r,
  output logic [WIDTH-1:0]                sout_l,
  output logic [$clog2(DEPTH+1)-1:0]      cnt,
  output logic                            done
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int N = WIDTH*DEPTH;
  localparam logic [CW-1:0] LAST = CW'(DEPTH-1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [N-1:0] nxt;
  logic mv, clr;
  assign mv = mode != 3'd0 && mode < 3'd5;
  assign clr = mode == 3'd5 || mode == 3'd6;
  assign sout_r = q[N-1 -: WIDTH];
  assign sout_l = q[WIDTH-1:0];
  // stage 0 sits in the low lane, so "right" moves data toward the high lanes
  always_comb begin
    nxt = mode == 3'd1 ? {q[N-WIDTH-1:0], sin_r} :
          mode == 3'd2 ? {sin_l, q[N-1:WIDTH]} :
          mode == 3'd3 ? {q[N-WIDTH-1:0], q[N-1 -: WIDTH]} :
          mode == 3'd4 ? {q[WIDTH-1:0], q[N-1:WIDTH]} :
          mode == 3'd5 ? pin :
          mode == 3'd6 ? '0 : q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      done <= en && mv && cnt == LAST;
      if (en) begin
        q <= nxt;
        cnt <= clr ? '0 : (mv && cnt != FULL) ? cnt + 1'b1 : cnt;
      end
    end
  end
endmodule
